// File: rtl/veritune_player_if.sv
// Sample-RAM read port between the Veritune player and the sample memory.
// The player drives the master side, and the memory model drives the slave side.
interface veritune_player_if #(
  parameter int ADDR_W = 14
);
  logic              Rd_En;
  logic [ADDR_W-1:0] Rd_Addr;
  logic              Rd_Data;

  modport master (output Rd_En, output Rd_Addr, input Rd_Data);
  modport slave  (input Rd_En, input Rd_Addr, output Rd_Data);
endinterface

// File: rtl/veritune_player.sv
// Veritune playback reader: a phase accumulator plays back the 1-bit recording pitch-shifted by Freq.
// Optional macro VERITUNE_PLAYER_LOOP_EN makes playback loop continuously instead of stopping after one pass.
module veritune_player #(
  parameter int ADDR_W     = 14,
  parameter int SAMPLE_DIV = 1024
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Play,
  input  logic [7:0]          Freq,
  input  logic [ADDR_W:0]     Rec_Len,
  veritune_player_if.master   mem,
  output logic                Audio_Out,
  output logic                Busy,
  output logic                Done
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_END,
    S_DONE_WAIT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W+7:0]   r_pos;
  logic [ADDR_W+7:0]   w_pos_sum;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_audio;
  logic                w_tick;
  logic                w_at_end;
  logic                w_busy;
  logic                w_rd_en;
  logic                w_done;

  // pos is fixed point with 7 fractional bits, so bits above 7 form the sample index.
  assign w_pos_sum = r_pos + {{ADDR_W{1'b0}}, Freq};
  assign w_at_end  = (w_pos_sum[ADDR_W+7:7] >= Rec_Len);
  assign w_tick    = (r_cnt == CNT_MAX);

  // NOTE: Every output is decoded from state or from a reset register. An asynchronous reset therefore clears all outputs without a clock edge.
  assign mem.Rd_En   = w_rd_en;
  assign mem.Rd_Addr = r_pos[ADDR_W+6:7];
  assign Audio_Out   = r_audio;
  assign Busy        = w_busy;
  assign Done        = w_done;

  // NOTE: Sequential blocks use non-blocking assignments only. Every always_comb output gets a default first, so no latches are inferred.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_rd_en      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Play && (Rec_Len != '0)) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        w_busy       = 1'b1;
        w_rd_en      = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        w_busy       = 1'b1;
        w_state_next = S_HOLD;
      end
      S_HOLD: begin
        w_busy = 1'b1;
        if (w_tick) w_state_next = w_at_end ? S_END : S_FETCH;
      end
      S_END: begin
        w_done = 1'b1;
`ifdef VERITUNE_PLAYER_LOOP_EN
        w_busy       = 1'b1;
        w_state_next = S_FETCH;
`else
        w_state_next = S_DONE_WAIT;
`endif
      end
      S_DONE_WAIT: w_state_next = S_DONE_WAIT;
      default:     w_state_next = S_IDLE;
    endcase
    // Dropping Play abandons playback from any state, and Done is not pulsed.
    if (!Play) w_state_next = S_IDLE;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pos   <= '0;
      r_cnt   <= '0;
      r_audio <= 1'b0;
    end else begin
      if (w_busy) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_audio <= 1'b0;
          if (w_state_next == S_FETCH) begin
            r_pos <= '0;
            r_cnt <= '0;
          end
        end
        S_WAIT: r_audio <= mem.Rd_Data;
        S_HOLD: begin
          if (w_tick && !w_at_end) r_pos <= w_pos_sum;
        end
        S_END: begin
          r_audio <= 1'b0;
`ifdef VERITUNE_PLAYER_LOOP_EN
          r_pos <= '0;
`endif
        end
        default: ;
      endcase
      if (!Play) r_audio <= 1'b0;
    end
  end

endmodule

// File: tb/tb_veritune_player.sv
// Self-checking bench for veritune_player. It compares the DUT against a tick-timeline model of playback.
module tb_veritune_player;

  localparam int ADDR_W     = 5;
  localparam int SAMPLE_DIV = 8;
  localparam int D          = SAMPLE_DIV;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int MAXN       = 512;
  localparam int RUN_CAP    = 400;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              Play = 1'b0;
  logic [7:0]        Freq = '0;
  logic [ADDR_W:0]   Rec_Len = '0;
  logic              Audio_Out;
  logic              Busy;
  logic              Done;

  veritune_player_if #(.ADDR_W(ADDR_W)) mem_if ();

  veritune_player #(.ADDR_W(ADDR_W), .SAMPLE_DIV(SAMPLE_DIV)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Play      (Play),
    .Freq      (Freq),
    .Rec_Len   (Rec_Len),
    .mem       (mem_if),
    .Audio_Out (Audio_Out),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  logic mem_q [DEPTH];
  always @(posedge Clk) begin
    if (mem_if.Rd_En) mem_if.Rd_Data <= mem_q[mem_if.Rd_Addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle outputs. Cycle 0 is the first cycle after Play is seen in IDLE.
  bit e_rden  [MAXN];
  bit e_busy  [MAXN];
  bit e_done  [MAXN];
  bit e_audio [MAXN];
  int e_addr  [MAXN];

  // A sample is fetched at t_f, and its value appears at t_f+2 and holds until replaced.
  // Ticks fall on every cycle t with t % D == D-1, because the divider runs from cycle 0.
  task automatic build_model(input int freq, input int rec_len, output int end_cycle);
    int pos, pos_n, idx, t_fetch, t_tick;
    for (int t = 0; t < MAXN; t++) begin
      e_rden[t] = 0; e_busy[t] = 0; e_done[t] = 0; e_audio[t] = 0; e_addr[t] = 0;
    end
    end_cycle = -1;
    if (rec_len == 0) return;
    pos = 0;
    t_fetch = 0;
    while (t_fetch < RUN_CAP) begin
      idx = pos / 128;
      e_rden[t_fetch] = 1;
      e_addr[t_fetch] = idx % DEPTH;
      for (int t = t_fetch + 2; t < MAXN; t++) e_audio[t] = mem_q[idx % DEPTH];
      t_tick = t_fetch + 2 + (((D - 1) - ((t_fetch + 2) % D) + D) % D);
      for (int t = t_fetch; t <= t_tick; t++) e_busy[t] = 1;
      pos_n = pos + freq;
      if (pos_n / 128 >= rec_len) begin
        e_done[t_tick + 1] = 1;
        for (int t = t_tick + 2; t < MAXN; t++) e_audio[t] = 0;
        if (end_cycle < 0) end_cycle = t_tick + 1;
`ifdef VERITUNE_PLAYER_LOOP_EN
        e_busy[t_tick + 1] = 1;
        pos = 0;
        t_fetch = t_tick + 2;
`else
        break;
`endif
      end else begin
        pos = pos_n;
        t_fetch = t_tick + 1;
      end
    end
  endtask

  // Plays one recording and drops Play after cycle t_drop. If n_req <= 0, the run length is derived from the model.
  task automatic run_play(input string name, input int freq, input int rec_len,
                          input int n_req, input int t_drop);
    int end_cycle, n;
    bit xr, xb, xd, xa;
    build_model(freq, rec_len, end_cycle);
    n = n_req;
    if (n <= 0) begin
`ifdef VERITUNE_PLAYER_LOOP_EN
      n = (end_cycle >= 0 && 3 * end_cycle + 6 < RUN_CAP) ? 3 * end_cycle + 6 : RUN_CAP;
`else
      n = (end_cycle >= 0 && end_cycle + 6 < RUN_CAP) ? end_cycle + 6 : RUN_CAP;
`endif
    end
    @(negedge Clk);
    Freq = 8'(freq);
    Rec_Len = (ADDR_W+1)'(rec_len);
    Play = 1'b1;
    @(posedge Clk);
    for (int t = 0; t < n; t++) begin
      @(negedge Clk);
      if (t > t_drop) begin
        xr = 0; xb = 0; xd = 0; xa = 0;
      end else begin
        xr = e_rden[t]; xb = e_busy[t]; xd = e_done[t]; xa = e_audio[t];
      end
      check($sformatf("%s rd_en@%0d", name, t), 32'(mem_if.Rd_En), 32'(xr));
      check($sformatf("%s busy@%0d", name, t), 32'(Busy), 32'(xb));
      check($sformatf("%s done@%0d", name, t), 32'(Done), 32'(xd));
      check($sformatf("%s audio@%0d", name, t), 32'(Audio_Out), 32'(xa));
      if (xr) check($sformatf("%s rd_addr@%0d", name, t), 32'(mem_if.Rd_Addr), 32'(e_addr[t]));
      if (t == t_drop) Play = 1'b0;
    end
    Play = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check($sformatf("%s idle_busy", name), 32'(Busy), 32'd0);
    check($sformatf("%s idle_audio", name), 32'(Audio_Out), 32'd0);
  endtask

  task automatic load_1011();
    for (int i = 0; i < DEPTH; i++) mem_q[i] = 1'b0;
    mem_q[0] = 1'b1; mem_q[1] = 1'b0; mem_q[2] = 1'b1; mem_q[3] = 1'b1;
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int freq, rec_len, n_drop;
    load_1011();
    #1 Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("reset rd_en", 32'(mem_if.Rd_En), 32'd0);
    check("reset rd_addr", 32'(mem_if.Rd_Addr), 32'd0);
    check("reset busy", 32'(Busy), 32'd0);
    check("reset done", 32'(Done), 32'd0);
    check("reset audio", 32'(Audio_Out), 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    run_play("unity", 128, 4, 0, RUN_CAP);
    run_play("half", 64, 4, 0, RUN_CAP);
    run_play("fast", 255, 4, 0, RUN_CAP);
    run_play("reclen0", 128, 0, 20, RUN_CAP);
    run_play("drop_hold", 128, 4, 12, 5);
    run_play("freq0", 0, 4, 60, RUN_CAP);
`ifdef VERITUNE_PLAYER_LOOP_EN
    run_play("loop2", 128, 2, 0, RUN_CAP);
`endif

    // Asynchronous reset while in WAIT, with Audio_Out holding a 1.
    @(negedge Clk);
    Freq = 8'd128; Rec_Len = (ADDR_W+1)'(4); Play = 1'b1;
    @(posedge Clk);
    repeat (10) @(negedge Clk);
    check("pre_reset audio", 32'(Audio_Out), 32'd1);
    check("pre_reset rd_addr", 32'(mem_if.Rd_Addr), 32'd1);
    #1 Reset = 1'b1;
    #1;
    check("async rst rd_en", 32'(mem_if.Rd_En), 32'd0);
    check("async rst rd_addr", 32'(mem_if.Rd_Addr), 32'd0);
    check("async rst busy", 32'(Busy), 32'd0);
    check("async rst done", 32'(Done), 32'd0);
    check("async rst audio", 32'(Audio_Out), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("restart rd_en", 32'(mem_if.Rd_En), 32'd1);
    check("restart rd_addr", 32'(mem_if.Rd_Addr), 32'd0);
    Play = 1'b0;
    repeat (2) @(negedge Clk);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] = 1'($urandom_range(0, 1));
      freq    = (r % 7 == 6) ? int'($urandom_range(0, 15)) : int'($urandom_range(16, 255));
      rec_len = int'($urandom_range(1, DEPTH));
      n_drop  = (r % 4 == 3) ? int'($urandom_range(0, 150)) : RUN_CAP;
      run_play($sformatf("rand%0d", r), freq, rec_len, 0, n_drop);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/veritune_player.md
Name: veritune_player

Overview:
- Playback reader for the Veritune recorder.
- Plays back the 1-bit audio stream that recording wrote into sample memory, pitch-shifted by the 8-bit Freq control.
- Sits between the top-level state machine and the sample RAM read port, and drives the board audio output.
- Playback speed comes from a fixed-point phase accumulator: Freq=128 is unity, 64 is half speed, 255 is about 2x.

Parameters:
ADDR_W, 14, sample memory address width (2^ADDR_W one-bit samples)
SAMPLE_DIV, 1024, clock cycles per output sample period; must be >= 4

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
Play  input  1  level; high while the top-level SM is in PLAY
Freq  input  8  pitch ratio, unsigned 1.7 fixed point (128 = 1.0)
Rec_Len  input  ADDR_W+1  number of valid recorded samples
Rd_En  output  1  memory read strobe
Rd_Addr  output  ADDR_W  memory read address
Rd_Data  input  1  read data, valid the cycle after Rd_En
Audio_Out  output  1  audio sample to output driver
Busy  output  1  high in FETCH/WAIT/HOLD
Done  output  1  one-cycle pulse when the end of the recording is reached

Behaviour:
- Reset, asynchronous: state=IDLE, pos=0, tick count=0. All outputs go to 0: Audio_Out, Rd_En, Rd_Addr, Busy, Done.
- pos: ADDR_W+8 bits, unsigned.
  - Integer index = pos[ADDR_W+7:7].
  - Rd_Addr = pos[ADDR_W+6:7].
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 while Busy and wraps to 0.
  - A tick occurs in the cycle where count == SAMPLE_DIV-1.
- IDLE:
  - Audio_Out=0.
  - If Play=1 and Rec_Len!=0: pos<=0, count<=0, go to FETCH.
  - If Play=1 and Rec_Len==0: stay in IDLE, no Done.
- FETCH (1 cycle): Rd_En=1, Rd_Addr=current index. Next state is WAIT.
- WAIT (1 cycle): Audio_Out<=Rd_Data at the end of the cycle. Next state is HOLD.
  - Audio_Out therefore updates 2 cycles after FETCH is entered.
- HOLD: Audio_Out holds its value until the tick. At the tick:
  - pos_next = pos + Freq, with Freq sampled in the tick cycle.
  - If the integer index of pos_next >= Rec_Len: go to END.
  - Otherwise pos<=pos_next and go to FETCH.
  - Same index (slow playback): the sample is re-fetched; this is harmless.
  - Freq=0: the index never advances; the current sample repeats indefinitely.
- END (1 cycle): Done=1, Audio_Out<=0. Next state is DONE_WAIT.
- DONE_WAIT: outputs idle; stays until Play=0, then goes to IDLE. There is no auto-restart while Play stays high.
- Play=0 in any state except IDLE: next cycle state=IDLE, Audio_Out=0, Rd_En=0, Busy=0. Pending ticks are discarded and Done is not pulsed.
- Rec_Len and Freq changes during playback take effect at the next tick comparison.
- Rd_En is never asserted outside FETCH. At most one read is outstanding.

Optional Feature:
VERITUNE_PLAYER_LOOP_EN
- Defined:
  - At END, Done still pulses, pos<=0 and the next state is FETCH, so playback loops continuously while Play=1.
  - DONE_WAIT is unreachable.
  - Busy stays 1 through END.
- Undefined: one-shot behaviour exactly as described above.

Test Plan:
1. Common setup for tests 1-3: SAMPLE_DIV=8, memory = 1,0,1,1.
   - Play=1, Freq=128, Rec_Len=4 -> Rd_Addr sequence 0,1,2,3, one fetch per 8 cycles.
   - Audio_Out sequence 1,0,1,1, each value held 8 cycles.
   - Done pulses once, 32 cycles after start. Audio_Out=0 afterwards; module stays in DONE_WAIT until Play=0.
2. Same setup, Freq=64 -> reads 0,0,1,1,2,2,3,3 over 8 ticks; Done after 64 cycles.
3. Same setup, Freq=255 -> pos 0,255,510,765 -> reads at indices 0,1,3; index 5 >= 4 triggers END.
   - Audio_Out sequence 1,0,1; Done at the third tick.
4. Play=1 with Rec_Len=0 -> no Rd_En, Busy=0, no Done.
   - Separately, Play dropped in HOLD -> next cycle IDLE with Audio_Out=0 and no Done.
5. Reset asserted in WAIT -> all outputs 0 immediately, without a clock edge. After release with Play=1, playback restarts at address 0.
6. With VERITUNE_PLAYER_LOOP_EN, Freq=128, Rec_Len=2, SAMPLE_DIV=8 -> addresses 0,1,0,1,... with Done pulsing every 16 cycles and Busy held at 1.
